mem_arbiter: RTL and testbench

- Shares the single-port `mem` block between N_REQ requesters, for example instruction fetch (req 0) and load/store (req 1).
- Uses round-robin arbitration and a per-requester req/ack handshake.
- Drives `mem` rd/wr/addr/data and captures the combinational read data into a per-requester register.
- Sits between the CPU front-end/LSU and `mem`; it is the only driver of `mem` strobes.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_rr_arbiter.sv | 42 ++++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter and the `mem` block.
//   mem_arb_state_t : arbiter FSM states (IDLE waits for a request, ACCESS drives mem)
//   ADDR_WIDTH      : default `mem` address width
//   DATA_WIDTH      : default `mem` data width
//   idx_width()     : bits needed to index n requesters (at least 1)
package mem_arb_pkg;

    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_arb_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first eligible index strictly after
// the last-grant pointer, wrapping from N_REQ-1 back to 0.
//   eligible  : requesters allowed to win this cycle
//   last      : index granted most recently
//   grant     : one-hot winner (all zero when nothing is eligible)
//   grant_idx : binary index of the winner (0 when nothing is eligible)
//   any_grant : some requester is eligible
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    int unsigned cand;

    // Scan N_REQ candidates starting one past the last winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = 32'(last) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!any_grant && eligible[cand[IDX_W-1:0]]) begin
                any_grant                = 1'b1;
                grant[cand[IDX_W-1:0]]   = 1'b1;
                grant_idx                = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port `mem` block between N_REQ requesters using
// round-robin arbitration and a per-requester req/ack handshake. Each
// access takes one ACCESS cycle; ack pulses for one cycle afterwards.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request, held until ack
//   req_wr     : per-requester 1 = write, 0 = read
//   req_addr   : per-requester address
//   req_wdata  : per-requester write data
//   ack        : one-cycle completion pulse per requester
//   rdata      : per-requester read data, held until that requester's next read
//   mem_rd     : `mem` read strobe
//   mem_wr     : `mem` write strobe
//   mem_addr   : `mem` address (meaningful only while a strobe is high)
//   mem_wdata  : `mem` write data
//   mem_rdata  : `mem` combinational read data (valid only while mem_rd=1)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned ADDR_WIDTH = mem_arb_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = mem_arb_pkg::DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_REQ-1:0]                     req,
    input  logic [N_REQ-1:0]                     req_wr,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_wdata,
    output logic [N_REQ-1:0]                     ack,
    output logic [N_REQ-1:0][DATA_WIDTH-1:0]     rdata,
    output logic                                 mem_rd,
    output logic                                 mem_wr,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    input  logic [DATA_WIDTH-1:0]                mem_rdata
);

    localparam int unsigned IDX_W = idx_width(N_REQ);

    mem_arb_state_t   state;
    mem_arb_state_t   next_state;
    logic             load;
    logic             finish;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] rr_grant;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_any;

    logic [IDX_W-1:0] last_ptr;
    logic [N_REQ-1:0] op_grant;
    logic [IDX_W-1:0] op_idx;
    logic             op_wr;

    // A requester whose ack is high this cycle still holds req; keep it out.
    assign eligible = req & ~ack;

    rr_arbiter #(
        .N_REQ     (N_REQ)
    ) u_rr (
        .eligible  (eligible),
        .last      (last_ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any_grant (rr_any)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the load/finish strobes that steer the datapath.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (rr_any) begin
                    next_state = ACCESS;
                    load       = 1'b1;
                end
            end
            ACCESS: begin
                next_state = IDLE;
                finish     = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Grant latch, mem strobes and response registers. Strobes are flops with
    // async clear, so reset drops them at once and an interrupted write is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ptr  <= IDX_W'(N_REQ - 1);
            op_grant  <= '0;
            op_idx    <= '0;
            op_wr     <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack       <= '0;
            rdata     <= '0;
        end else begin
            ack <= '0;
            if (load) begin
                last_ptr  <= rr_idx;
                op_grant  <= rr_grant;
                op_idx    <= rr_idx;
                op_wr     <= req_wr[rr_idx];
                mem_rd    <= ~req_wr[rr_idx];
                mem_wr    <= req_wr[rr_idx];
                mem_addr  <= req_addr[rr_idx];
                mem_wdata <= req_wdata[rr_idx];
            end
            if (finish) begin
                mem_rd <= 1'b0;
                mem_wr <= 1'b0;
                ack    <= op_grant;
                if (!op_wr) begin
                    rdata[op_idx] <= mem_rdata;
                end
            end
        end
    end

    // Handshake and bus sanity.
    a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));
    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_rd && mem_wr));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// phase, all checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned IW = idx_width(N);
    localparam int unsigned MEM_WORDS = 1 << AW;

    logic                   clk;
    logic                   rst_n;
    logic [N-1:0]           req;
    logic [N-1:0]           req_wr;
    logic [N-1:0][AW-1:0]   req_addr;
    logic [N-1:0][DW-1:0]   req_wdata;
    logic [N-1:0]           ack;
    logic [N-1:0][DW-1:0]   rdata;
    logic                   mem_rd;
    logic                   mem_wr;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_wdata;
    logic [DW-1:0]          mem_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter #(
        .N_REQ      (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // ---------------- `mem` device model ----------------
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == AW'(16)) return DW'(223);
        if (a == AW'(30)) return DW'(32'h1111);
        return DW'(a) * DW'(32'h0101_0101) + DW'(5);
    endfunction

    logic [DW-1:0] mem_arr [MEM_WORDS];
    bit            written [MEM_WORDS];

    always @(posedge clk) begin
        if (mem_wr) begin
            mem_arr[mem_addr] <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return written[a] ? mem_arr[a] : init_val(a);
    endfunction

    assign mem_rdata = mem_rd ? mem_val(mem_addr) : DW'(32'hDEAD_BEEF);

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] ix(input int i);
        return IW'(i);
    endfunction

    // ---------------- reference model ----------------
    // One transaction in flight at most; it is issued on a clock edge, occupies
    // the following cycle on the mem bus, and completes (ack) on the next edge.
    logic [DW-1:0] ref_mem [MEM_WORDS];
    logic [DW-1:0] exp_rdata [N];
    int            m_ack;     // requester acked in the current cycle, -1 none
    bit            m_busy;    // a transaction is on the mem bus this cycle
    int            m_last;    // most recently granted requester
    int            t_idx;
    bit            t_wr;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;

    int strobe_cnt;
    int wr_cnt;
    int ack_log [$];

    task automatic model_reset();
        m_ack  = -1;
        m_busy = 1'b0;
        m_last = N - 1;
        foreach (exp_rdata[i]) exp_rdata[i] = '0;
    endtask

    // Predict the effect of the coming clock edge given the current inputs.
    task automatic model_advance();
        int  n_ack;
        bit  granted;
        n_ack   = -1;
        granted = 1'b0;
        if (m_busy) begin
            n_ack = t_idx;
            if (t_wr) ref_mem[t_addr] = t_wdata;
            else      exp_rdata[t_idx] = ref_mem[t_addr];
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (!granted && req[ix(c)] && c != m_ack) begin
                    granted = 1'b1;
                    t_idx   = c;
                    t_wr    = req_wr[ix(c)];
                    t_addr  = req_addr[ix(c)];
                    t_wdata = req_wdata[ix(c)];
                    m_last  = c;
                end
            end
        end
        m_busy = granted;
        m_ack  = n_ack;
    endtask

    task automatic check_outputs();
        logic [N-1:0] ea;
        ea = '0;
        if (m_ack >= 0) ea[ix(m_ack)] = 1'b1;
        check_eq("ack", 64'(ack), 64'(ea));
        check_eq("mem_rd", 64'(mem_rd), 64'(m_busy && !t_wr));
        check_eq("mem_wr", 64'(mem_wr), 64'(m_busy && t_wr));
        if (m_busy) check_eq("mem_addr", 64'(mem_addr), 64'(t_addr));
        if (m_busy && t_wr) check_eq("mem_wdata", 64'(mem_wdata), 64'(t_wdata));
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("rdata%0d", i), 64'(rdata[ix(i)]), 64'(exp_rdata[i]));
        end
        check_eq("strobe_excl", 64'(mem_rd & mem_wr), 64'(0));
        check_eq("ack_onehot0", 64'($onehot0(ack)), 64'(1));
    endtask

    // Advance one clock: model predicts, DUT clocks, compare at the negedge.
    task automatic tick();
        model_advance();
        @(negedge clk);
        check_outputs();
        strobe_cnt += int'(mem_rd | mem_wr);
        wr_cnt     += int'(mem_wr);
        for (int i = 0; i < N; i++) begin
            if (ack[ix(i)]) ack_log.push_back(i);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic set_req(input int i, input bit wr, input int unsigned addr, input logic [DW-1:0] d);
        req[ix(i)]       = 1'b1;
        req_wr[ix(i)]    = wr;
        req_addr[ix(i)]  = AW'(addr);
        req_wdata[ix(i)] = d;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom), $urandom_range(0, 15), DW'($urandom));
    endtask

    // Single uncontended transaction; returns req->ack latency in cycles.
    task automatic do_txn(input int i, input bit wr, input int unsigned addr,
                          input logic [DW-1:0] d, output int lat);
        set_req(i, wr, addr, d);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ack[ix(i)] && lat < 20);
        if (!ack[ix(i)]) check_eq("txn_timeout", 64'(ack[ix(i)]), 64'(1));
        req[ix(i)] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs();
    endtask

    initial begin
        int            lat;
        int            a0;
        int            a1;
        int            rem [N];
        logic [DW-1:0] old21;
        logic [DW-1:0] old30;

        rst_n     = 1'b0;
        req       = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        strobe_cnt = 0;
        wr_cnt     = 0;
        for (int unsigned a = 0; a < MEM_WORDS; a++) ref_mem[a] = init_val(AW'(a));
        do_reset();

        // Write then read, requester 0.
        wr_cnt = 0;
        do_txn(0, 1'b1, 15, DW'(123), lat);
        check_eq("t1_wr_lat", 64'(lat), 64'(2));
        idle(1);
        do_txn(0, 1'b0, 15, DW'(0), lat);
        check_eq("t1_rd_lat", 64'(lat), 64'(2));
        check_eq("t1_wr_once", 64'(wr_cnt), 64'(1));
        check_eq("t1_rdata", 64'(rdata[0]), 64'(123));

        // Simultaneous reads right after reset: requester 0 first.
        do_reset();
        set_req(0, 1'b0, 16, DW'(0));
        set_req(1, 1'b0, 15, DW'(0));
        a0 = -1;
        a1 = -1;
        for (int c = 1; c <= 12 && (a0 < 0 || a1 < 0); c++) begin
            tick();
            if (ack[0]) begin a0 = c; req[0] = 1'b0; end
            if (ack[1]) begin a1 = c; req[1] = 1'b0; end
        end
        check_eq("t2_ack0_cycle", 64'(a0), 64'(2));
        check_eq("t2_ack1_cycle", 64'(a1), 64'(4));
        check_eq("t2_rdata0", 64'(rdata[0]), 64'(223));
        check_eq("t2_rdata1", 64'(rdata[1]), 64'(123));

        // Fairness: both requesters keep requesting, four accesses each.
        idle(1);
        ack_log.delete();
        strobe_cnt = 0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 4;
            rand_req(i);
        end
        repeat (16) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (ack[ix(i)]) begin
                    rem[i]--;
                    if (rem[i] > 0) rand_req(i);
                    else req[ix(i)] = 1'b0;
                end
            end
        end
        check_eq("t3_ack_count", 64'(ack_log.size()), 64'(8));
        for (int k = 0; k < ack_log.size(); k++) begin
            check_eq($sformatf("t3_order%0d", k), 64'(ack_log[k]), 64'(k % 2));
        end
        check_eq("t3_duty", 64'(strobe_cnt), 64'(8));

        // Address/data changes after the grant edge are ignored.
        idle(1);
        old21 = mem_val(AW'(21));
        set_req(1, 1'b1, 20, DW'(55));
        tick();
        req_addr[1]  = AW'(21);
        req_wdata[1] = DW'(99);
        tick();
        check_eq("t4_ack1", 64'(ack[1]), 64'(1));
        req[1] = 1'b0;
        check_eq("t4_mem20", 64'(mem_val(AW'(20))), 64'(55));
        check_eq("t4_mem21", 64'(mem_val(AW'(21))), 64'(old21));

        // Reset in the middle of a write ACCESS.
        idle(1);
        old30 = mem_val(AW'(30));
        set_req(0, 1'b1, 30, DW'(77));
        tick();
        check_eq("t5_wr_before", 64'(mem_wr), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_wr_async", 64'(mem_wr), 64'(0));
        check_eq("t5_rd_async", 64'(mem_rd), 64'(0));
        check_eq("t5_ack_rst", 64'(ack), 64'(0));
        check_eq("t5_rdata_rst", 64'(rdata), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        set_req(0, 1'b0, 30, DW'(0));
        set_req(1, 1'b0, 15, DW'(0));
        ack_log.delete();
        for (int c = 0; c < 12 && ack_log.size() < 2; c++) begin
            tick();
            for (int i = 0; i < N; i++) if (ack[ix(i)]) req[ix(i)] = 1'b0;
        end
        check_eq("t5_acks", 64'(ack_log.size()), 64'(2));
        if (ack_log.size() > 0) check_eq("t5_first_grant", 64'(ack_log[0]), 64'(0));
        check_eq("t5_mem30", 64'(mem_val(AW'(30))), 64'(old30));
        check_eq("t5_rdata0", 64'(rdata[0]), 64'(old30));

        // Back-to-back requests from requester 0 alone.
        idle(1);
        do_txn(0, 1'b0, 20, DW'(0), lat);
        check_eq("t6_lat_a", 64'(lat), 64'(2));
        idle(1);
        do_txn(0, 1'b1, 41, DW'(32'hCAFE_0001), lat);
        check_eq("t6_lat_b", 64'(lat), 64'(2));
        idle(1);
        do_txn(0, 1'b0, 41, DW'(0), lat);
        check_eq("t6_lat_c", 64'(lat), 64'(2));
        check_eq("t6_rdata", 64'(rdata[0]), 64'(32'hCAFE_0001));

        // Randomized traffic.
        idle(1);
        repeat (400) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (ack[ix(i)]) begin
                    if ($urandom_range(0, 1) == 1) rand_req(i);
                    else req[ix(i)] = 1'b0;
                end else if (m_busy && t_idx == i) begin
                    req_addr[ix(i)]  = AW'($urandom_range(0, 15));
                    req_wdata[ix(i)] = DW'($urandom);
                end else if (!req[ix(i)] && $urandom_range(0, 2) == 0) begin
                    rand_req(i);
                end
            end
        end
        req = '0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
